bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Consumes the 16-bit, 4-digit BCD count bus `q` from the decimal counter stage. `q[3:0]` is the units digit; `q[15:12]` is the thousands digit.
- Drives a time-multiplexed 4-digit common-anode seven-segment display.
- Snapshots the count once per scan frame to prevent tearing. Rotates through the digits at a parameterised refresh rate.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit is lit. Legal range is 2 or more.
- SEG_ACTIVE_LOW, 1: if 1, `seg` and `dp` are driven inverted (0 = lit).
- AN_ACTIVE_LOW, 1: if 1, `an` is driven inverted (0 = digit enabled).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset. reset=0 at a rising clk edge resets the block.
- q  in  16  BCD count from the counter. Nibble k is digit k; k=0 is the units digit.
- dp_in  in  4  decimal-point request per digit. Sampled together with `q`.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point for the currently lit digit.
- an  out  4  digit enables, one-hot in logical (active-high) form. `an[k]` enables digit k.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset (reset=0 at an edge):
  - prescaler=0, idx=0, snapshot=0, load_pending=1.
  - `an` all inactive, `seg`/`dp` all unlit, `frame_done`=0.
  - Reset takes priority over every other event, including mid-frame.
- Prescaler:
  - Counts 0..REFRESH_DIV-1. `tick` is asserted while prescaler==REFRESH_DIV-1; the prescaler wraps to 0 on the following edge.
- Digit index:
  - On `tick`, idx advances 0→1→2→3→0. idx is held otherwise.
- Control FSM, states LOAD and SCAN:
  - LOAD is entered out of reset (load_pending=1). On the first post-reset edge, snapshot<={dp_in,q}, load_pending<=0, go to SCAN.
  - SCAN: on `tick` with idx==3, snapshot<={dp_in,q} and `frame_done` pulses for exactly one cycle, on the same edge that idx returns to 0.
  - `q` changes at any other time have no effect until the next frame boundary.
- Output pipeline:
  - `an`/`seg`/`dp` are registered from (idx, snapshot), giving 1-cycle latency after an idx change.
  - Exactly one `an` bit is active at all times outside reset. A digit is therefore lit REFRESH_DIV cycles per frame; the frame is 4*REFRESH_DIV cycles.
- Decode, logical active-high, a = bit0:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles A–F decode to 40 (dash, segment g only) and dp is forced off for that digit.
- Polarity:
  - Inversion per SEG_ACTIVE_LOW / AN_ACTIVE_LOW is applied at the output register only.
  - The reset-inactive values are the inverted logical zero: e.g. all-ones when ACTIVE_LOW=1.
- Simultaneous events:
  - reset=0 on a `tick` edge resets the block; `frame_done` is not pulsed.
  - If REFRESH_DIV==2, `tick` alternates every cycle and all rules above still hold.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k=3..1) is blanked (seg unlit, dp unlit) when its snapshot nibble and all higher nibbles are 0.
  - Digit 0 is never blanked; value 0000 shows "   0".
  - The `an` rotation is unchanged.
  - An invalid nibble (>9) counts as non-zero, so it is never blanked.
- Undefined: all four digits are always decoded, so zeros are shown.

Decomposition:
- Package `bcd_display_pkg`:
  - Segment constants SEG_0..SEG_9, SEG_DASH (7'h40), SEG_BLANK (7'h00).
  - Typedef `digit_idx_t` (2-bit).
  - FSM state enum {LOAD, SCAN}.
- Sub-module `bcd_to_seg7`: purely combinational nibble→7-segment decoder with an invalid flag. Instantiated once, driven by the muxed snapshot nibble.

Test Plan:
- Reset and refresh (REFRESH_DIV=4, polarity params=0, `q`=16'h1234): hold reset=0 for 3 cycles, then release.
  - During reset: an=0000, seg=00.
  - After release: an=0001 with seg=66 ("4"), then an=0010 seg=4F, an=0100 seg=5B, an=1000 seg=06, each for 4 cycles.
  - `frame_done` pulses every 16 cycles.
- Snapshot isolation: change `q` to 16'h9876 while digit 1 is lit.
  - Displayed digits stay 1234 until the wrap; the next frame shows 9876 (digit 0 seg=7D).
- Invalid BCD (`q`=16'h0A05): digit 1 shows seg=40 with dp forced off even when dp_in[1]=1. Digit 0 shows 6D.
- Reset mid-frame: drive reset=0 while digit 2 is lit.
  - Next edge: outputs inactive and idx=0.
  - After release, the snapshot reloads the current `q` on the first edge.
- Polarity (params=1, `q`=16'h0008): digit 0 shows seg=7'h00 and an=4'b1110. During reset, all outputs are 1.
- LEADING_ZERO_BLANK_EN defined, `q`=16'h0050: digits 3 and 2 are unlit, digit 1 seg=6D, digit 0 seg=3F. With `q`=0000, only digit 0 shows 3F.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared definitions for the multiplexed BCD seven-segment display scanner.
// Segment patterns are logical (1 = segment lit), bit order {g,f,e,d,c,b,a}.
package bcd_display_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Index of the digit currently being scanned, 0 = units digit.
   typedef logic [1:0] digit_idx_t;

   // Control FSM: LOAD takes the first snapshot after reset, SCAN rotates digits.
   typedef enum logic [0:0] {
      LOAD = 1'b0,
      SCAN = 1'b1
   } ctrl_state_e;

   // Plain-vector copies of the state encodings for legacy state registers.
   localparam logic [0:0] ST_LOAD = LOAD;
   localparam logic [0:0] ST_SCAN = SCAN;

   // Logical (active-high) one-hot digit enable for a digit index.
   function automatic logic [3:0] digit_onehot(input digit_idx_t i);
      return 4'b0001 << i;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to seven-segment decoder.
// Valid digits 0-9 map to their glyphs; A-F show a dash and raise 'invalid'
// so the caller can suppress the decimal point for that digit.
module bcd_to_seg7
   import bcd_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg,
   output logic       invalid
);

   // Glyph lookup, with non-BCD codes falling through to the dash pattern.
   always_comb begin
      seg     = SEG_DASH;
      invalid = 1'b0;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: begin
            seg     = SEG_DASH;
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit common-anode seven-segment scanner.
// The BCD count is snapshotted once per scan frame so a digit never shows a
// mix of old and new values; each digit is lit for REFRESH_DIV clocks
// (REFRESH_DIV must be 2 or more).
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 is always shown, invalid nibbles count as non-zero).
module bcd_display_scanner
   import bcd_display_pkg::*;
#(
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] q,
   input  logic [3:0]  dp_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam int              PW      = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0]   PRE_MAX = PW'(REFRESH_DIV - 1);

   // XOR masks that turn logical values into pin levels; also the idle levels.
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

   logic [PW-1:0] prescaler;
   logic          tick;
   digit_idx_t    idx;
   logic [0:0]    state;
   logic [19:0]   snapshot;
   logic [19:0]   disp_src;
   logic          frame_wrap;

   logic [3:0]    nib;
   logic          dp_req;
   logic [3:0]    blank;
   logic          digit_blank;
   logic [6:0]    dec_seg;
   logic          dec_invalid;
   logic [6:0]    seg_logic;
   logic          dp_logic;

   // Refresh strobe: high during the last prescaler count of each digit slot.
   always_comb begin
      tick       = (prescaler == PRE_MAX);
      frame_wrap = (state == ST_SCAN) && tick && (idx == 2'd3);
   end

   // Prescaler counting 0..REFRESH_DIV-1 and wrapping after the tick cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   // Digit index rotation 0->1->2->3->0, one step per tick.
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx <= '0;
      end else if (tick) begin
         idx <= idx + 2'd1;
      end
   end

   // Control FSM: first snapshot right after reset, then once per frame wrap.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_LOAD;
         snapshot   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_wrap;
         case (state)
            ST_LOAD: begin
               snapshot <= {dp_in, q};
               state    <= ST_SCAN;
            end
            ST_SCAN: begin
               if (frame_wrap) begin
                  snapshot <= {dp_in, q};
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   // While LOAD is capturing, show the value being captured rather than the
   // cleared snapshot, so digit 0 is correct from the first lit cycle.
   always_comb begin
      disp_src = (state == ST_LOAD) ? {dp_in, q} : snapshot;
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is blanked when it and every digit above it are zero.
   always_comb begin
      blank    = 4'b0000;
      blank[3] = (disp_src[15:12] == 4'd0);
      blank[2] = blank[3] && (disp_src[11:8] == 4'd0);
      blank[1] = blank[2] && (disp_src[7:4] == 4'd0);
      blank[0] = 1'b0;
   end
`else
   // All digits are always decoded, leading zeros included.
   always_comb begin
      blank = 4'b0000;
   end
`endif

   // Select the nibble, decimal-point request and blank flag of the lit digit.
   always_comb begin
      nib         = disp_src[3:0];
      dp_req      = disp_src[16];
      digit_blank = blank[0];
      case (idx)
         2'd1: begin
            nib         = disp_src[7:4];
            dp_req      = disp_src[17];
            digit_blank = blank[1];
         end
         2'd2: begin
            nib         = disp_src[11:8];
            dp_req      = disp_src[18];
            digit_blank = blank[2];
         end
         2'd3: begin
            nib         = disp_src[15:12];
            dp_req      = disp_src[19];
            digit_blank = blank[3];
         end
         default: begin
            nib         = disp_src[3:0];
            dp_req      = disp_src[16];
            digit_blank = blank[0];
         end
      endcase
   end

   bcd_to_seg7 u_decoder (
      .nibble  (nib),
      .seg     (dec_seg),
      .invalid (dec_invalid)
   );

   // Final logical pattern: blanking wins, invalid digits never show a point.
   always_comb begin
      seg_logic = digit_blank ? SEG_BLANK : dec_seg;
      dp_logic  = dp_req && !dec_invalid && !digit_blank;
   end

   // Output register; pin polarity is applied here and nowhere else.
   always_ff @(posedge clk) begin
      if (!reset) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= DP_OFF;
      end else begin
         an  <= digit_onehot(idx) ^ AN_OFF;
         seg <= seg_logic ^ SEG_OFF;
         dp  <= dp_logic ^ DP_OFF;
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with REFRESH_DIV=4.
// Two instances share clock and reset: one with active-high pins, one with
// active-low pins fed a constant count. Expected digits are queued per frame.
module tb_bcd_display_scanner;

   logic        clk;
   logic        reset;
   logic [15:0] q;
   logic [3:0]  dp_in;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   logic [15:0] q_pol;
   logic [3:0]  dp_pol;
   logic [6:0]  pseg;
   logic        pdp;
   logic [3:0]  pan;
   logic        pframe_done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [3:0] pan;
      logic [6:0] pseg;
      logic       pdp;
   } exp_t;

   exp_t sb[$];

   bcd_display_scanner #(
      .REFRESH_DIV    (4),
      .SEG_ACTIVE_LOW (1'b0),
      .AN_ACTIVE_LOW  (1'b0)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .q          (q),
      .dp_in      (dp_in),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   bcd_display_scanner #(
      .REFRESH_DIV    (4),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) u_pol (
      .clk        (clk),
      .reset      (reset),
      .q          (q_pol),
      .dp_in      (dp_pol),
      .seg        (pseg),
      .dp         (pdp),
      .an         (pan),
      .frame_done (pframe_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference glyph table, logical polarity.
   function automatic logic [6:0] model_seg(input logic [3:0] n);
      case (n)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // Logical segment and point for digit k of a count.
   task automatic model_digit(input logic [15:0] qv, input logic [3:0] dv, input int k,
                              output logic [6:0] s, output logic d);
      logic [3:0] nb;
      logic       blk;
      nb = qv[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      blk = (k != 0) && ((qv >> (4*k)) == 16'h0000);
`else
      blk = 1'b0;
`endif
      s = blk ? 7'h00 : model_seg(nb);
      d = dv[k] && (nb <= 4'd9) && !blk;
   endtask

   // Queue the four digits one frame of the given count should display.
   task automatic applyStimulus(input logic [15:0] qv, input logic [3:0] dv);
      exp_t       e;
      logic [6:0] s;
      logic       d;
      for (int k = 0; k < 4; k++) begin
         model_digit(qv, dv, k, s, d);
         e.an  = 4'b0001 << k;
         e.seg = s;
         e.dp  = d;
         model_digit(q_pol, dp_pol, k, s, d);
         e.pan  = ~(4'b0001 << k);
         e.pseg = ~s;
         e.pdp  = ~d;
         sb.push_back(e);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Both instances must show their idle (reset) levels.
   task automatic checkIdle(input string tag);
      checkOutput({tag, " an"},   {4'h0, an},          8'h00);
      checkOutput({tag, " seg"},  {1'b0, seg},         8'h00);
      checkOutput({tag, " dp"},   {7'h0, dp},          8'h00);
      checkOutput({tag, " fd"},   {7'h0, frame_done},  8'h00);
      checkOutput({tag, " pan"},  {4'h0, pan},         8'h0F);
      checkOutput({tag, " pseg"}, {1'b0, pseg},        8'h7F);
      checkOutput({tag, " pdp"},  {7'h0, pdp},         8'h01);
   endtask

   // Walk one 16-cycle frame, starting at the negedge just before digit 0
   // is registered; optionally change the count at cycle chg_cyc.
   task automatic checkFrame(input string tag, input int chg_cyc,
                             input logic [15:0] chg_q, input logic [3:0] chg_dp);
      exp_t  e;
      string t;
      e = '0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == chg_cyc) begin
            q     = chg_q;
            dp_in = chg_dp;
         end
         if ((c - 1) % 4 == 0) begin
            checkOutput($sformatf("%s c%0d sb_has_entry", tag, c), {7'h0, (sb.size() > 0)}, 8'h01);
            if (sb.size() > 0) e = sb.pop_front();
         end
         t = $sformatf("%s c%0d", tag, c);
         checkOutput({t, " an"},   {4'h0, an},           {4'h0, e.an});
         checkOutput({t, " seg"},  {1'b0, seg},          {1'b0, e.seg});
         checkOutput({t, " dp"},   {7'h0, dp},           {7'h0, e.dp});
         checkOutput({t, " fd"},   {7'h0, frame_done},   {7'h0, (c == 16)});
         checkOutput({t, " pan"},  {4'h0, pan},          {4'h0, e.pan});
         checkOutput({t, " pseg"}, {1'b0, pseg},         {1'b0, e.pseg});
         checkOutput({t, " pdp"},  {7'h0, pdp},          {7'h0, e.pdp});
         checkOutput({t, " pfd"},  {7'h0, pframe_done},  {7'h0, (c == 16)});
      end
   endtask

   // Directed sequence: reset, refresh, snapshot isolation, invalid digits,
   // zero handling, mid-frame reset and reload.
   initial begin
      reset  = 1'b0;
      q      = 16'h1234;
      dp_in  = 4'h0;
      q_pol  = 16'h0008;
      dp_pol = 4'h0;

      repeat (3) begin
         @(negedge clk);
         checkIdle("reset");
      end
      reset = 1'b1;

      applyStimulus(16'h1234, 4'h0);
      checkFrame("f1_1234", 0, 16'h0000, 4'h0);

      applyStimulus(16'h1234, 4'h0);
      checkFrame("f2_hold", 6, 16'h9876, 4'h0);

      applyStimulus(16'h9876, 4'h0);
      checkFrame("f3_9876", 6, 16'h0A05, 4'b0011);

      applyStimulus(16'h0A05, 4'b0011);
      checkFrame("f4_invalid", 6, 16'h0050, 4'h0);

      applyStimulus(16'h0050, 4'h0);
      checkFrame("f5_0050", 6, 16'h0000, 4'h0);

      applyStimulus(16'h0000, 4'h0);
      checkFrame("f6_zero", 0, 16'h0000, 4'h0);

      repeat (10) @(negedge clk);
      checkOutput("midrst digit2 lit", {4'h0, an}, 8'h04);
      reset = 1'b0;
      q     = 16'h4321;
      dp_in = 4'b0100;
      @(negedge clk);
      checkIdle("midrst1");
      @(negedge clk);
      checkIdle("midrst2");
      reset = 1'b1;

      applyStimulus(16'h4321, 4'b0100);
      checkFrame("f7_reload", 0, 16'h0000, 4'h0);

      checkOutput("sb_empty", {7'h0, (sb.size() == 0)}, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
